// File: rtl/ifetch_prefetch_queue_if.sv
// rtl/ifetch_prefetch_queue_if.sv - fetch-stage bundle: redirect, instruction memory handshake, decode-side head
interface ifetch_prefetch_queue_if #(
  parameter int CW = 3
);
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          stall_d;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic [31:0]   instrD;
  logic [31:0]   pcp1D;
  logic          validD;
  logic [CW-1:0] occupancy;

  modport master (
    input  redirect, redirect_pc, stall_d, imem_ack, imem_rdata,
    output imem_req, imem_addr, instrD, pcp1D, validD, occupancy
  );

  modport slave (
    output redirect, redirect_pc, stall_d, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instrD, pcp1D, validD, occupancy
  );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// rtl/ifetch_prefetch_queue.sv - fetch PC owner, single-outstanding imem requester and prefetch FIFO feeding decode
module ifetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          CW       = $clog2(DEPTH + 1)
) (
  input  logic CLK,
  input  logic rst,
  ifetch_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state, state_n;
  logic [31:0]   fpc, fpc_n;
  logic [31:0]   addr_q, addr_n;
  logic [CW-1:0] count, next_count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pcp1_mem  [DEPTH];
  logic          push, pop, empty, space;

  assign empty      = (count == '0);
  assign pop        = !empty && !bus.redirect && !bus.stall_d;
  assign push       = (state == REQ) && bus.imem_ack && !bus.redirect;
  assign next_count = count + CW'(push) - CW'(pop);
  assign space      = (next_count < CW'(DEPTH));

  assign bus.imem_req  = (state != IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.validD    = !empty && !bus.redirect;
  assign bus.instrD    = empty ? 32'h0 : instr_mem[rd_ptr];
  assign bus.pcp1D     = empty ? 32'h0 : pcp1_mem[rd_ptr];
  assign bus.occupancy = count;

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    fpc_n   = fpc;
    if (bus.redirect) begin
      fpc_n = bus.redirect_pc;
    end else if (push) begin
      fpc_n = fpc + 32'd1;
    end

    case (state)
      IDLE: begin
        if (bus.redirect) begin
          state_n = REQ;
          addr_n  = bus.redirect_pc;
        end else if (space) begin
          state_n = REQ;
          addr_n  = fpc;
        end
      end
      REQ: begin
        // Without an ack the old address must stay on the bus until it completes.
        if (bus.redirect) begin
          if (bus.imem_ack) begin
            addr_n = bus.redirect_pc;
          end else begin
            state_n = DRAIN;
          end
        end else if (bus.imem_ack) begin
          if (space) begin
            addr_n = fpc + 32'd1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DRAIN: begin
        if (bus.imem_ack) begin
          state_n = REQ;
          addr_n  = bus.redirect ? bus.redirect_pc : fpc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      fpc    <= RESET_PC;
      addr_q <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state  <= state_n;
      fpc    <= fpc_n;
      addr_q <= addr_n;
      if (bus.redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= next_count;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is zero.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.imem_rdata;
      pcp1_mem[wr_ptr]  <= fpc + 32'd1;
    end
  end
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb/tb_ifetch_prefetch_queue.sv - directed self-checking bench for ifetch_prefetch_queue
module tb_ifetch_prefetch_queue;
  logic CLK;
  logic rst;
  logic auto_mode;
  logic man_ack;
  logic [31:0] man_rdata;
  int n_checks;
  int n_fail;

  ifetch_prefetch_queue_if #(.CW(3)) bus();

  ifetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .CW(3)) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // zero-wait memory in auto mode, hand-driven otherwise
  always_comb begin
    if (auto_mode) begin
      bus.imem_ack   = bus.imem_req;
      bus.imem_rdata = 32'hA000_0000 | bus.imem_addr;
    end else begin
      bus.imem_ack   = man_ack;
      bus.imem_rdata = man_rdata;
    end
  end

  task automatic reset_dut(input logic a_mode, input logic stall);
    @(negedge CLK);
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.stall_d = stall;
    auto_mode = a_mode;
    man_ack = 1'b0;
    man_rdata = 32'h0;
    @(negedge CLK);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h exp 0", bus.imem_addr); end
    n_checks++; if (bus.validD !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", bus.validD); end
    n_checks++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d exp 0", bus.occupancy); end
    n_checks++; if (bus.instrD !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h exp 0", bus.instrD); end
    n_checks++; if (bus.pcp1D !== 32'h0) begin n_fail++; $display("FAIL reset_pcp1: got %h exp 0", bus.pcp1D); end
  endtask

  task automatic test_stream;
    reset_dut(1'b1, 1'b0);
    @(negedge CLK);
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_first_req: got req %b addr %h exp 1 0", bus.imem_req, bus.imem_addr); end
    n_checks++; if (bus.validD !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid: got %b exp 0", bus.validD); end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      n_checks++; if (bus.validD !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b exp 1", k, bus.validD); end
      n_checks++; if (bus.instrD !== (32'hA000_0000 | k)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h exp %h", k, bus.instrD, 32'hA000_0000 | k); end
      n_checks++; if (bus.pcp1D !== 32'(k + 1)) begin n_fail++; $display("FAIL stream_pcp1[%0d]: got %h exp %h", k, bus.pcp1D, k + 1); end
      n_checks++; if (bus.imem_addr !== 32'(k + 1)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h exp %h", k, bus.imem_addr, k + 1); end
      n_checks++; if (bus.occupancy !== 3'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d exp 1", k, bus.occupancy); end
    end
  endtask

  task automatic test_stall_full;
    reset_dut(1'b1, 1'b1);
    repeat (6) @(negedge CLK);
    n_checks++; if (bus.occupancy !== 3'd4) begin n_fail++; $display("FAIL full_occ: got %0d exp 4", bus.occupancy); end
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b exp 0", bus.imem_req); end
    n_checks++; if (bus.instrD !== 32'hA000_0000 || bus.pcp1D !== 32'h1) begin n_fail++; $display("FAIL full_head: got %h/%h exp a0000000/1", bus.instrD, bus.pcp1D); end
    bus.stall_d = 1'b0;
    @(negedge CLK);
    n_checks++; if (bus.instrD !== 32'hA000_0001 || bus.occupancy !== 3'd3) begin n_fail++; $display("FAIL release_pop1: got %h occ %0d exp a0000001 occ 3", bus.instrD, bus.occupancy); end
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL release_resume: got req %b addr %h exp 1 4", bus.imem_req, bus.imem_addr); end
    @(negedge CLK);
    n_checks++; if (bus.instrD !== 32'hA000_0002 || bus.occupancy !== 3'd3 || bus.imem_addr !== 32'h5) begin n_fail++; $display("FAIL release_pop2: got %h occ %0d addr %h exp a0000002 3 5", bus.instrD, bus.occupancy, bus.imem_addr); end
  endtask

  task automatic test_redirect_idle;
    reset_dut(1'b1, 1'b1);
    repeat (6) @(negedge CLK);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    #1;
    n_checks++; if (bus.validD !== 1'b0) begin n_fail++; $display("FAIL redir_idle_valid: got %b exp 0", bus.validD); end
    @(negedge CLK);
    bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL redir_idle_occ: got %0d exp 0", bus.occupancy); end
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_idle_req: got req %b addr %h exp 1 40", bus.imem_req, bus.imem_addr); end
    @(negedge CLK);
    n_checks++; if (bus.validD !== 1'b1 || bus.pcp1D !== 32'h41 || bus.instrD !== 32'hA000_0040) begin n_fail++; $display("FAIL redir_idle_first: got v %b pcp1 %h instr %h exp 1 41 a0000040", bus.validD, bus.pcp1D, bus.instrD); end
  endtask

  task automatic test_redirect_drain;
    reset_dut(1'b0, 1'b1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h5;
    @(negedge CLK);
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h5) begin n_fail++; $display("FAIL drain_req5: got req %b addr %h exp 1 5", bus.imem_req, bus.imem_addr); end
    bus.redirect_pc = 32'h80;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      bus.redirect = 1'b0;
      n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h5 || bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL drain_hold[%0d]: got req %b addr %h occ %0d exp 1 5 0", c, bus.imem_req, bus.imem_addr, bus.occupancy); end
    end
    man_ack = 1'b1;
    man_rdata = 32'hDEAD_0005;
    @(negedge CLK);
    man_ack = 1'b0;
    n_checks++; if (bus.imem_addr !== 32'h80 || bus.imem_req !== 1'b1 || bus.occupancy !== 3'd0 || bus.validD !== 1'b0) begin n_fail++; $display("FAIL drain_next: got addr %h req %b occ %0d v %b exp 80 1 0 0", bus.imem_addr, bus.imem_req, bus.occupancy, bus.validD); end
    @(negedge CLK);
    n_checks++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL drain_wait_occ: got %0d exp 0", bus.occupancy); end
    man_ack = 1'b1;
    man_rdata = 32'hA000_0080;
    @(negedge CLK);
    man_ack = 1'b0;
    n_checks++; if (bus.occupancy !== 3'd1 || bus.instrD !== 32'hA000_0080 || bus.pcp1D !== 32'h81) begin n_fail++; $display("FAIL drain_fill: got occ %0d instr %h pcp1 %h exp 1 a0000080 81", bus.occupancy, bus.instrD, bus.pcp1D); end
  endtask

  task automatic test_ack_redirect;
    reset_dut(1'b0, 1'b0);
    @(negedge CLK);
    man_ack = 1'b1;
    man_rdata = 32'hBAD0_0000;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h10;
    @(negedge CLK);
    man_ack = 1'b0;
    bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.imem_addr !== 32'h10 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL ackredir_addr: got addr %h req %b exp 10 1", bus.imem_addr, bus.imem_req); end
    n_checks++; if (bus.occupancy !== 3'd0 || bus.validD !== 1'b0) begin n_fail++; $display("FAIL ackredir_occ: got occ %0d v %b exp 0 0", bus.occupancy, bus.validD); end
  endtask

  task automatic test_wrap;
    reset_dut(1'b1, 1'b1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    @(negedge CLK);
    bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_req: got %h exp ffffffff", bus.imem_addr); end
    @(negedge CLK);
    n_checks++; if (bus.pcp1D !== 32'h0 || bus.validD !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_pcp1: got pcp1 %h v %b addr %h exp 0 1 0", bus.pcp1D, bus.validD, bus.imem_addr); end
  endtask

  task automatic test_async_reset;
    reset_dut(1'b1, 1'b1);
    repeat (3) @(negedge CLK);
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0 || bus.validD !== 1'b0 || bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL areset_ctl: got req %b v %b occ %0d exp 0 0 0", bus.imem_req, bus.validD, bus.occupancy); end
    n_checks++; if (bus.instrD !== 32'h0 || bus.pcp1D !== 32'h0 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL areset_data: got instr %h pcp1 %h addr %h exp 0 0 0", bus.instrD, bus.pcp1D, bus.imem_addr); end
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL areset_restart: got req %b addr %h occ %0d exp 1 0 0", bus.imem_req, bus.imem_addr, bus.occupancy); end
    @(negedge CLK);
    n_checks++; if (bus.instrD !== 32'hA000_0000 || bus.occupancy !== 3'd1) begin n_fail++; $display("FAIL areset_first: got instr %h occ %0d exp a0000000 1", bus.instrD, bus.occupancy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    auto_mode = 1'b1;
    man_ack = 1'b0;
    man_rdata = 32'h0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.stall_d = 1'b0;
    test_reset();
    test_stream();
    test_stall_full();
    test_redirect_idle();
    test_redirect_drain();
    test_ack_redirect();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
